// File: rtl/wb_queue.sv
// Write-back FIFO in front of the register file's write port, with two hazard lookup ports.
// Define WBQ_BYPASS_EN to build youngest-match forwarding on FwdData1/2; otherwise those outputs are tied to 0.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            WbValid,
    output logic            WbReady,
    input  logic [4:0]      WbReg,
    input  logic [31:0]     WbData,
    input  logic            DrainEn,
    output logic            RegWrite,
    output logic [4:0]      WriteRegister,
    output logic [31:0]     WriteData,
    input  logic [4:0]      LookupReg1,
    input  logic [4:0]      LookupReg2,
    output logic            Pending1,
    output logic            Pending2,
    output logic [31:0]     FwdData1,
    output logic [31:0]     FwdData2,
    output logic [PTRW:0]   Count
);
    localparam logic [PTRW:0]   FULL = (PTRW + 1)'(DEPTH);
    localparam logic [PTRW:0]   CNT1 = (PTRW + 1)'(1);
    localparam logic [PTRW-1:0] PTR1 = PTRW'(1);

    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [DEPTH-1:0][4:0]    reg_q;
    logic [DEPTH-1:0][31:0]   data_q;
    logic [PTRW-1:0]          head_q, tail_q;
    logic [PTRW:0]            cnt_q;
    logic                     push, pop, nonempty;

    assign nonempty = (cnt_q != '0);
    assign WbReady  = Reset_n && (cnt_q != FULL);
    // Writes to $zero complete the handshake but are dropped here.
    assign push     = WbValid && WbReady && (WbReg != 5'd0);
    assign pop      = Reset_n && DrainEn && nonempty;

    assign RegWrite      = pop;
    assign WriteRegister = nonempty ? reg_q[head_q]  : 5'd0;
    assign WriteData     = nonempty ? data_q[head_q] : 32'd0;
    assign Count         = cnt_q;

    always_comb begin
        vld_d = vld_q;
        if (pop)  vld_d[head_q] = 1'b0;
        if (push) vld_d[tail_q] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            vld_q <= vld_d;
            if (push) tail_q <= tail_q + PTR1;
            if (pop)  head_q <= head_q + PTR1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT1;
                2'b01:   cnt_q <= cnt_q - CNT1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage needs no reset: vld_q and cnt_q gate every use of it.
    always_ff @(posedge Clk) begin
        if (push) begin
            reg_q[tail_q]  <= WbReg;
            data_q[tail_q] <= WbData;
        end
    end

    always_comb begin
        Pending1 = 1'b0;
        Pending2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (reg_q[i] == LookupReg1) && (LookupReg1 != 5'd0)) Pending1 = 1'b1;
            if (vld_q[i] && (reg_q[i] == LookupReg2) && (LookupReg2 != 5'd0)) Pending2 = 1'b1;
        end
    end

`ifdef WBQ_BYPASS_EN
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [PTRW-1:0] idx;
        idx      = '0;
        FwdData1 = '0;
        FwdData2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTRW'(k);
            if (vld_q[idx] && (reg_q[idx] == LookupReg1)) FwdData1 = data_q[idx];
            if (vld_q[idx] && (reg_q[idx] == LookupReg2)) FwdData2 = data_q[idx];
        end
    end
`else
    assign FwdData1 = '0;
    assign FwdData2 = '0;
`endif

endmodule
